// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NUM_REQ byte sources share one uart_tx.
// It runs IDLE -> SEND -> GAP, has a watchdog in SEND, and registers every output.
module uart_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*8-1:0]       data_i,
  input  logic [TIMEOUT_W-1:0]       timeout_lim_i,
  input  logic                       tx_done_i,
  output logic                       tx_en_o,
  output logic [7:0]                 tx_data_o,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       timeout_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o
);

  localparam int OW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // The MSB is the valid flag. The index is the first set request after 'last', wrapping.
  function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [OW-1:0]      last);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(last) + 1 + i) % NUM_REQ;
      if (req[idx]) begin
        res = {1'b1, OW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] k);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] slot(input logic [NUM_REQ*8-1:0] d,
                                      input logic [OW-1:0]        k);
    return d[8*int'(k) +: 8];
  endfunction

  logic [1:0]           state_r, state_s;
  logic [OW-1:0]        last_r, last_s;
  logic [OW-1:0]        owner_r, owner_s;
  logic [7:0]           data_r, data_s;
  logic [TIMEOUT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [NUM_REQ-1:0]   ack_r, ack_s, done_r, done_s;
  logic                 tmo_r, tmo_s;
  logic                 tx_en_r, busy_r;
  logic [OW:0]          pick_s;
  logic                 expire_s;

  // Arbitration result and watchdog status for the current cycle.
  always_comb begin
    pick_s    = rr_pick(req_i, last_r);
    cnt_inc_s = (&cnt_r) ? cnt_r : (cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1});
    // Expire on an exact match, or at saturation if the limit dropped below the count.
    expire_s  = (timeout_lim_i != {TIMEOUT_W{1'b0}}) &&
                ((cnt_r == timeout_lim_i) || (&cnt_r));
  end

  // Next-state logic. The pulse outputs default to zero on every cycle.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    owner_s = owner_r;
    data_s  = data_r;
    cnt_s   = cnt_r;
    ack_s   = '0;
    done_s  = '0;
    tmo_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_s[OW]) begin
          state_s = ST_SEND;
          last_s  = pick_s[OW-1:0];
          owner_s = pick_s[OW-1:0];
          data_s  = slot(data_i, pick_s[OW-1:0]);
          cnt_s   = '0;
          ack_s   = onehot(pick_s[OW-1:0]);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tx_done_i) begin
          done_s  = onehot(owner_r);
          state_s = ST_GAP;
        end else if (expire_s) begin
          tmo_s   = 1'b1;
          state_s = ST_GAP;
        end else begin
          cnt_s   = cnt_inc_s;
        end
      end
      ST_GAP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset forces IDLE immediately and gives requester 0 first priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      last_r  <= OW'(NUM_REQ - 1);
      owner_r <= '0;
      data_r  <= 8'h00;
      cnt_r   <= '0;
      ack_r   <= '0;
      done_r  <= '0;
      tmo_r   <= 1'b0;
      tx_en_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      owner_r <= owner_s;
      data_r  <= data_s;
      cnt_r   <= cnt_s;
      ack_r   <= ack_s;
      done_r  <= done_s;
      tmo_r   <= tmo_s;
      tx_en_r <= (state_s == ST_SEND);
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign tx_en_o   = tx_en_r;
  assign tx_data_o = data_r;
  assign ack_o     = ack_r;
  assign done_o    = done_r;
  assign timeout_o = tmo_r;
  assign busy_o    = busy_r;
  assign owner_o   = owner_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb with the default parameters (4 requesters).
module tb_uart_tx_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  req_i = 4'b0000;
  logic [31:0] data_i = 32'h4433_2211;
  logic [19:0] timeout_lim_i = 20'd0;
  logic        tx_done_i = 1'b0;
  logic        tx_en_o;
  logic [7:0]  tx_data_o;
  logic [3:0]  ack_o;
  logic [3:0]  done_o;
  logic        timeout_o;
  logic        busy_o;
  logic [1:0]  owner_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_tx_arb #(.NUM_REQ(4), .TIMEOUT_W(20)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .timeout_lim_i(timeout_lim_i), .tx_done_i(tx_done_i), .tx_en_o(tx_en_o),
    .tx_data_o(tx_data_o), .ack_o(ack_o), .done_o(done_o), .timeout_o(timeout_o),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Step until an ack appears, giving up after a bounded number of cycles.
  task automatic wait_ack();
    int w;
    w = 0;
    while (ack_o === 4'b0000 && w < 8) begin
      step();
      w++;
    end
  endtask

  task automatic xfer(input int idx, input int dur, input logic [7:0] exp_data);
    wait_ack();
    check("xfer_ack", {28'd0, ack_o}, 32'd1 << idx);
    check("xfer_owner", {30'd0, owner_o}, idx);
    check("xfer_data", {24'd0, tx_data_o}, {24'd0, exp_data});
    check("xfer_en", {31'd0, tx_en_o}, 32'd1);
    repeat (dur - 1) step();
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
    check("xfer_done", {28'd0, done_o}, 32'd1 << idx);
    check("xfer_gap_en", {31'd0, tx_en_o}, 32'd0);
    check("xfer_no_tmo", {31'd0, timeout_o}, 32'd0);
  endtask

  initial begin
    int k;
    int en_cnt;
    logic saw;

    // Reset state
    #1 rst_i = 1'b1;
    #1;
    check("rst_en", {31'd0, tx_en_o}, 32'd0);
    check("rst_data", {24'd0, tx_data_o}, 32'd0);
    check("rst_ack", {28'd0, ack_o}, 32'd0);
    check("rst_done", {28'd0, done_o}, 32'd0);
    check("rst_tmo", {31'd0, timeout_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_owner", {30'd0, owner_o}, 32'd0);
    step();
    step();
    rst_i = 1'b0;

    // Round-robin with all requests held: 0,1,2,3,0
    req_i = 4'b1111;
    xfer(0, 10, 8'h11);
    step();
    check("rr_idle_gap_en", {31'd0, tx_en_o}, 32'd0);
    check("rr_idle_busy", {31'd0, busy_o}, 32'd0);
    xfer(1, 10, 8'h22);
    xfer(2, 10, 8'h33);
    xfer(3, 10, 8'h44);
    xfer(0, 10, 8'h11);
    req_i = 4'b0000;
    step();
    step();

    // Single request from slot 2, held for 160 cycles
    data_i = 32'h44A5_2211;
    req_i  = 4'b0100;
    wait_ack();
    check("single_ack", {28'd0, ack_o}, 32'h4);
    check("single_owner", {30'd0, owner_o}, 32'd2);
    check("single_data", {24'd0, tx_data_o}, 32'hA5);
    check("single_busy", {31'd0, busy_o}, 32'd1);
    req_i  = 4'b0000;
    data_i = 32'h0000_0000;
    en_cnt = (tx_en_o === 1'b1) ? 1 : 0;
    step();
    check("single_ack_pulse", {28'd0, ack_o}, 32'd0);
    for (int i = 1; i < 160; i++) begin
      if (tx_en_o === 1'b1) en_cnt++;
      if (i < 159) step();
    end
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
    check("single_en_cycles", en_cnt, 32'd160);
    check("single_done", {28'd0, done_o}, 32'h4);
    check("single_gap_en", {31'd0, tx_en_o}, 32'd0);
    check("single_gap_busy", {31'd0, busy_o}, 32'd1);
    check("single_data_hold", {24'd0, tx_data_o}, 32'hA5);
    step();
    check("single_done_pulse", {28'd0, done_o}, 32'd0);
    check("single_idle_busy", {31'd0, busy_o}, 32'd0);
    data_i = 32'h4433_2211;

    // A tx_done in IDLE is ignored
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
    check("idle_done_ignored", {28'd0, done_o}, 32'd0);
    step();

    // Wrap-around: take grant 3, then 1001 goes to 0 and then to 3
    req_i = 4'b1000;
    xfer(3, 4, 8'h44);
    req_i = 4'b1001;
    xfer(0, 4, 8'h11);
    xfer(3, 4, 8'h44);
    req_i = 4'b0000;
    step();
    step();

    // Watchdog with limit 50: the timeout pulse comes 51 cycles after ack
    timeout_lim_i = 20'd50;
    req_i = 4'b0010;
    wait_ack();
    check("wd_ack", {28'd0, ack_o}, 32'h2);
    req_i = 4'b0100;
    k = 0;
    saw = 1'b0;
    while (timeout_o !== 1'b1 && k < 100) begin
      step();
      k++;
      if (done_o !== 4'b0000) saw = 1'b1;
    end
    check("wd_latency", k, 32'd51);
    check("wd_no_done", {31'd0, saw}, 32'd0);
    check("wd_gap_en", {31'd0, tx_en_o}, 32'd0);
    step();
    check("wd_tmo_pulse", {31'd0, timeout_o}, 32'd0);
    timeout_lim_i = 20'd0;
    xfer(2, 5, 8'h33);
    req_i = 4'b0000;
    step();
    step();

    // A limit of 0 never times out
    req_i = 4'b0001;
    wait_ack();
    check("wd0_ack", {28'd0, ack_o}, 32'h1);
    req_i = 4'b0000;
    saw = 1'b0;
    repeat (300) begin
      step();
      if (timeout_o !== 1'b0) saw = 1'b1;
    end
    check("wd0_no_tmo", {31'd0, saw}, 32'd0);
    check("wd0_still_en", {31'd0, tx_en_o}, 32'd1);
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
    check("wd0_done", {28'd0, done_o}, 32'h1);
    step();
    step();

    // Collision: tx_done arrives on the cycle the counter equals the limit, so done wins
    timeout_lim_i = 20'd20;
    req_i = 4'b0010;
    xfer(1, 21, 8'h22);
    req_i = 4'b0000;
    timeout_lim_i = 20'd0;
    step();
    step();

    // Reset mid-SEND clears outputs without a clock edge, then requester 0 wins first
    req_i = 4'b1111;
    wait_ack();
    check("rst_mid_en", {31'd0, tx_en_o}, 32'd1);
    step();
    step();
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_en", {31'd0, tx_en_o}, 32'd0);
    check("rst_async_busy", {31'd0, busy_o}, 32'd0);
    check("rst_async_owner", {30'd0, owner_o}, 32'd0);
    step();
    check("rst_no_done", {28'd0, done_o}, 32'd0);
    check("rst_no_tmo", {31'd0, timeout_o}, 32'd0);
    rst_i = 1'b0;
    step();
    check("post_rst_ack", {28'd0, ack_o}, 32'h1);
    check("post_rst_owner", {30'd0, owner_o}, 32'd0);
    check("post_rst_data", {24'd0, tx_data_o}, 32'h11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
